// File: rtl/bmat_unit.sv
// ---------------------------------------------------------------------------
// bmat_unit -- 8x8 bit-matrix multiply unit for the 64-bit bitmanip datapath.
//
// Operations (op):
//   00 : bmat OR   rd[8r+i] = |_j (rs1[8r+j] & rs2[8j+i])
//   01 : bmat XOR  rd[8r+i] = ^_j (rs1[8r+j] & rs2[8j+i])
//   10 : bmat FLIP rd[8r+i] = rs1[8i+r]  (only with BMAT_FLIP_EN, else OR)
//   11 : reserved, executes as OR
//
// Optional feature macro: BMAT_FLIP_EN
//   defined     -> op 10 transposes rs1, result one cycle after accept
//   not defined -> no transpose path on rs1; op 10 runs as OR
//
// Parameter:
//   ROWS_PER_CYCLE : result rows per compute cycle (1, 2, 4 or 8);
//                    OR/XOR take 8/ROWS_PER_CYCLE compute cycles.
//
// Ports:
//   clock      in   clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   operation request
//   in_ready   out  request can be accepted this cycle
//   op[1:0]    in   operation select
//   rs1[63:0]  in   left matrix, byte r is row r
//   rs2[63:0]  in   right matrix, byte j is row j
//   out_valid  out  result available on rd
//   out_ready  in   consumer takes the result
//   rd[63:0]   out  result matrix (held until the next result completes)
//   busy       out  compute in progress
// ---------------------------------------------------------------------------
module bmat_unit #(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] rd,
  output logic        busy
);

  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 ||
        ROWS_PER_CYCLE == 4 || ROWS_PER_CYCLE == 8)) begin : g_bad_rows_per_cycle
    $error("bmat_unit: ROWS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam int         N_CYCLES = 8 / ROWS_PER_CYCLE;
  localparam logic [2:0] LAST_CNT = 3'(N_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        w_accept;
  logic        w_last;
  logic        w_do_flip;

  logic [2:0]  r_cnt;
  logic        r_xor;
  logic [63:0] r_rs1;
  logic [63:0] r_cols;      // rs2 transposed: byte i holds column i of rs2
  logic [63:0] r_acc;
  logic [63:0] r_rd;
  logic [63:0] w_acc_next;

  logic [2:0]  w_row;
  logic [7:0]  w_row_bits;
  logic [7:0]  w_row_res;

  // Swap row/column index of an 8x8 bit matrix: t[8a+b] = m[8b+a].
  // Used both to pre-transpose rs2 into columns and for FLIP.
  function automatic logic [63:0] transpose8(input logic [63:0] m);
    logic [63:0] t;
    t = '0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        t[8*a+b] = m[8*b+a];
      end
    end
    return t;
  endfunction

`ifdef BMAT_FLIP_EN
  logic r_flip;
  assign w_do_flip = r_flip;
`else
  assign w_do_flip = 1'b0;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST_CNT);
  assign rd       = r_rd;

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_COMP;
      S_COMP: if (w_do_flip || w_last) w_state_next = S_DONE;
      // Handoff and new accept may share one edge, so no bubble.
      S_DONE: if (out_ready) w_state_next = in_valid ? S_COMP : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_COMP: busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Row slice for this compute cycle: rows are produced from 7 downward,
  // ROWS_PER_CYCLE at a time, each row dotted against the eight columns.
  always_comb begin
    w_acc_next = r_acc;
    w_row      = '0;
    w_row_bits = '0;
    w_row_res  = '0;
    for (int m = 0; m < ROWS_PER_CYCLE; m++) begin
      w_row      = 3'(7 - int'(r_cnt) * ROWS_PER_CYCLE - m);
      w_row_bits = r_rs1[{w_row, 3'b000} +: 8];
      for (int i = 0; i < 8; i++) begin
        w_row_res[i] = r_xor ? ^(w_row_bits & r_cols[8*i +: 8])
                             : |(w_row_bits & r_cols[8*i +: 8]);
      end
      w_acc_next[{w_row, 3'b000} +: 8] = w_row_res;
    end
  end

  // Operand capture, accumulation and result register. rd only updates on
  // the completing edge so it holds the previous result while computing.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_rd  <= '0;
`ifdef BMAT_FLIP_EN
      r_flip <= 1'b0;
`endif
    end else if (w_accept) begin
      r_rs1  <= rs1;
      r_cols <= transpose8(rs2);
      r_xor  <= (op == 2'b01);
`ifdef BMAT_FLIP_EN
      r_flip <= (op == 2'b10);
`endif
      r_cnt  <= '0;
    end else if (r_state == S_COMP) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 3'd1;
      if (w_do_flip) begin
`ifdef BMAT_FLIP_EN
        r_rd <= transpose8(r_rs1);
`endif
      end else if (w_last) begin
        r_rd <= w_acc_next;
      end
    end
  end

endmodule

// File: tb/tb_bmat_unit.sv
// ---------------------------------------------------------------------------
// tb_bmat_unit -- directed testbench for bmat_unit.
// Main instance uses ROWS_PER_CYCLE = 1; three auxiliary instances
// (2, 4, 8 rows per cycle) share operands and check per-width latency.
// ---------------------------------------------------------------------------
module tb_bmat_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] rd;
  logic        busy;

  logic        in_valid_x;
  logic        out_ready_x;
  logic        ir2, ov2, b2;
  logic        ir4, ov4, b4;
  logic        ir8, ov8, b8;
  logic [63:0] rd2, rd4, rd8;

  int vectors;
  int miscompares;

  localparam logic [63:0] IDENT = 64'h8040201008040201;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  bmat_unit #(.ROWS_PER_CYCLE(1)) u_r1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
    .out_ready(out_ready), .rd(rd), .busy(busy)
  );

  bmat_unit #(.ROWS_PER_CYCLE(2)) u_r2 (
    .clock(clock), .reset(reset), .in_valid(in_valid_x), .in_ready(ir2),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(ov2),
    .out_ready(out_ready_x), .rd(rd2), .busy(b2)
  );

  bmat_unit #(.ROWS_PER_CYCLE(4)) u_r4 (
    .clock(clock), .reset(reset), .in_valid(in_valid_x), .in_ready(ir4),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(ov4),
    .out_ready(out_ready_x), .rd(rd4), .busy(b4)
  );

  bmat_unit #(.ROWS_PER_CYCLE(8)) u_r8 (
    .clock(clock), .reset(reset), .in_valid(in_valid_x), .in_ready(ir8),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(ov8),
    .out_ready(out_ready_x), .rd(rd8), .busy(b8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the main instance with out_ready held high: checks
  // acceptance, latency, busy duration, result, and return to idle.
  task automatic run_op(input logic [1:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp,
                        input int lat_exp, input string tag);
    int lat;
    int bcnt;
    op        = o;
    rs1       = a;
    rs2       = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(lat_exp));
    check({tag, ".busy_cycles"}, 64'(bcnt), 64'(lat_exp));
    check({tag, ".rd"}, rd, exp);
    tick();
    check({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int lat2, lat4, lat8;
    logic [63:0] held;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_valid_x  = 1'b0;
    out_ready   = 1'b0;
    out_ready_x = 1'b1;
    op          = 2'b00;
    rs1         = '0;
    rs2         = '0;

    // Reset state
    tick();
    tick();
    check("reset.in_ready",  64'(in_ready),  64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.busy",      64'(busy),      64'd0);
    check("reset.rd",        rd,             64'd0);
    reset = 1'b0;
    tick();

    // XOR with identity, 1 row/cycle
    run_op(2'b01, 64'h0123456789ABCDEF, IDENT, 64'h0123456789ABCDEF, 8, "xor_id_r1");

    // Same on the 2/4/8 rows-per-cycle instances
    op         = 2'b01;
    rs1        = 64'h0123456789ABCDEF;
    rs2        = IDENT;
    in_valid_x = 1'b1;
    tick();
    in_valid_x = 1'b0;
    check("xor_id_r8.busy", 64'(b8), 64'd1);
    lat2 = 0;
    lat4 = 0;
    lat8 = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ov2 && lat2 == 0) lat2 = c;
      if (ov4 && lat4 == 0) lat4 = c;
      if (ov8 && lat8 == 0) lat8 = c;
    end
    check("xor_id_r2.latency", 64'(lat2), 64'd4);
    check("xor_id_r4.latency", 64'(lat4), 64'd2);
    check("xor_id_r8.latency", 64'(lat8), 64'd1);
    check("xor_id_r2.rd", rd2, 64'h0123456789ABCDEF);
    check("xor_id_r4.rd", rd4, 64'h0123456789ABCDEF);
    check("xor_id_r8.rd", rd8, 64'h0123456789ABCDEF);

    // OR reduction against all-ones
    run_op(2'b00, 64'h00FF000100000080, ONES, 64'h00FF00FF000000FF, 8, "or_reduce");

    // XOR parity: even and odd popcount rows
    run_op(2'b01, 64'h0000000000000003, ONES, 64'h0000000000000000, 8, "xor_par_even");
    run_op(2'b01, 64'h0000000000000001, ONES, 64'h00000000000000FF, 8, "xor_par_odd");

    // op 10: transpose when enabled, otherwise OR with normal latency
`ifdef BMAT_FLIP_EN
    run_op(2'b10, 64'h00000000000000FF, IDENT, 64'h0101010101010101, 1, "flip");
`else
    run_op(2'b10, 64'h00000000000000FF, IDENT, 64'h00000000000000FF, 8, "flip_as_or");
`endif

    // op 11 behaves as OR
    run_op(2'b11, 64'h00FF000100000080, ONES, 64'h00FF00FF000000FF, 8, "op11_as_or");

    // Backpressure, then handoff plus new accept on the same edge
    op        = 2'b00;
    rs1       = 64'h00FF000100000080;
    rs2       = ONES;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp.first_latency", 64'(lat), 64'd8);
    check("bp.first_rd", rd, 64'h00FF00FF000000FF);
    held     = rd;
    op       = 2'b01;
    rs1      = ONES;
    rs2      = ONES;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp.in_ready_low", 64'(in_ready), 64'd0);
      tick();
      check("bp.out_valid_held", 64'(out_valid), 64'd1);
      check("bp.rd_held", rd, held);
    end
    rs1       = 64'hDEADBEEFCAFEF00D;
    rs2       = IDENT;
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_on_handoff", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp.out_valid_after_handoff", 64'(out_valid), 64'd0);
    check("bp.busy_after_handoff", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp.second_latency", 64'(lat), 64'd8);
    check("bp.second_rd", rd, 64'hDEADBEEFCAFEF00D);
    tick();

    // Reset three cycles into an XOR
    op       = 2'b01;
    rs1      = 64'h0123456789ABCDEF;
    rs2      = IDENT;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.busy",      64'(busy),      64'd0);
    check("midrst.rd",        rd,             64'd0);
    check("midrst.in_ready",  64'(in_ready),  64'd1);
    run_op(2'b01, 64'hA5A55A5A0F0FF0F0, IDENT, 64'hA5A55A5A0F0FF0F0, 8, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
